// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scan controller. Drives one row at a time,
// samples the columns through a 2-flop synchronizer and debounces press and release.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic [7:0] keypad_val,
  output logic       new_key
);

  localparam int DW_W = $clog2(SCAN_DIV);
  localparam int DB_W = $clog2(DEBOUNCE);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  // The transition fires one count early so the registered outputs land on count DEBOUNCE-1.
  localparam logic [DB_W-1:0] DEB_LAST   = DB_W'(DEBOUNCE - 2);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  state_t            state, state_nx;
  logic [1:0]        row_idx, row_nx;
  logic [1:0]        col_idx, col_nx;
  logic [DW_W-1:0]   dwell, dwell_nx;
  logic [DB_W-1:0]   deb, deb_nx;
  logic [3:0]        key_code_nx;
  logic [7:0]        keypad_val_nx;
  logic              new_key_nx;
  logic [3:0]        cols_p0, cs;
  logic              col_low;

  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0])      low_col = 2'd0;
    else if (!c[1]) low_col = 2'd1;
    else if (!c[2]) low_col = 2'd2;
    else            low_col = 2'd3;
  endfunction

  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    decode_key = 4'h0;
    case ({r, c})
      4'b00_00: decode_key = 4'h1;
      4'b00_01: decode_key = 4'h2;
      4'b00_10: decode_key = 4'h3;
      4'b00_11: decode_key = 4'hA;
      4'b01_00: decode_key = 4'h4;
      4'b01_01: decode_key = 4'h5;
      4'b01_10: decode_key = 4'h6;
      4'b01_11: decode_key = 4'hB;
      4'b10_00: decode_key = 4'h7;
      4'b10_01: decode_key = 4'h8;
      4'b10_10: decode_key = 4'h9;
      4'b10_11: decode_key = 4'hC;
      4'b11_00: decode_key = 4'hE;
      4'b11_01: decode_key = 4'h0;
      4'b11_10: decode_key = 4'hF;
      4'b11_11: decode_key = 4'hD;
    endcase
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    row_drive = ~(4'b0001 << r);
  endfunction

  assign col_low = ~cs[col_idx];

  always_comb begin
    state_nx      = state;
    row_nx        = row_idx;
    col_nx        = col_idx;
    dwell_nx      = dwell;
    deb_nx        = deb;
    key_code_nx   = key_code;
    keypad_val_nx = keypad_val;
    new_key_nx    = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nx = '0;
          if (cs != 4'b1111) begin
            col_nx   = low_col(cs);
            deb_nx   = '0;
            state_nx = DEB_PRESS;
          end else begin
            row_nx = row_idx + 2'd1;
          end
        end else begin
          dwell_nx = dwell + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (!col_low) begin
          state_nx = SCAN;
          row_nx   = row_idx + 2'd1;
          dwell_nx = '0;
        end else if (deb == DEB_LAST) begin
          key_code_nx   = decode_key(row_idx, col_idx);
          keypad_val_nx = {4'b0001 << row_idx, 4'b0001 << col_idx};
          new_key_nx    = 1'b1;
          state_nx      = HELD;
        end else begin
          deb_nx = deb + 1'b1;
        end
      end
      HELD: begin
        if (!col_low) begin
          deb_nx   = '0;
          state_nx = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (col_low) begin
          state_nx = HELD;
        end else if (deb == DEB_LAST) begin
          state_nx = SCAN;
          row_nx   = row_idx + 2'd1;
          dwell_nx = '0;
        end else begin
          deb_nx = deb + 1'b1;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      row_idx    <= 2'd0;
      col_idx    <= 2'd0;
      dwell      <= '0;
      deb        <= '0;
      rows       <= 4'b1110;
      key_code   <= 4'h0;
      keypad_val <= 8'h00;
      new_key    <= 1'b0;
      cols_p0    <= 4'b1111;
      cs         <= 4'b1111;
    end else begin
      state      <= state_nx;
      row_idx    <= row_nx;
      col_idx    <= col_nx;
      dwell      <= dwell_nx;
      deb        <= deb_nx;
      rows       <= row_drive(row_nx);
      key_code   <= key_code_nx;
      keypad_val <= keypad_val_nx;
      new_key    <= new_key_nx;
      cols_p0    <= cols;
      cs         <= cols_p0;
    end
  end

endmodule
